// File: rtl/exe_branch_resolve_pkg.sv
// ============================================================================
// Module   : exe_branch_resolve_pkg
// Purpose  : Shared FSM encodings, branch type codes and the predictor
//            update record used by the EXE-stage branch resolver.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package exe_branch_resolve_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_DS  = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [1:0] BR_TYPE_COND = 2'd0;
    localparam logic [1:0] BR_TYPE_JUMP = 2'd1;
    localparam logic [1:0] BR_TYPE_CALL = 2'd2;
    localparam logic [1:0] BR_TYPE_RET  = 2'd3;

    localparam int UPD_REC_W = 68;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [1:0]  btype;
        logic        alloc;
    } upd_rec_t;

    // Fall-through address skips the delay slot; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus8(input logic [31:0] pc);
        return pc + 32'd8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/exe_branch_resolve_bp_upd_fifo.sv
// ============================================================================
// Module   : bp_upd_fifo
// Purpose  : Synchronous FIFO for predictor training records with a
//            valid/ready read side and a drop-on-full indication.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bp_upd_fifo
    import exe_branch_resolve_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = UPD_REC_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full;
    logic          pop;
    logic          push_ok;

    always_comb begin
        out_valid = (count_q != '0);
        out_data  = mem_q[rd_ptr_q];
        full      = (count_q == (AW+1)'(DEPTH));
        pop       = out_valid & out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push_ok   = push & (~full | pop);
        drop      = push & full & ~pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/exe_branch_resolve.sv
// ============================================================================
// Module   : exe_branch_resolve
// Purpose  : EXE-stage branch resolution: redirect/flush on mispredict with
//            delay-slot handling, predictor training queue, perf counters.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module exe_branch_resolve
    import exe_branch_resolve_pkg::*;
#(
    parameter int UPD_DEPTH = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             EXE_wr,
    input  logic             exe_valid,
    input  logic             EXE_is_branch,
    input  logic             EXE_is_branch_likely,
    input  logic             EXE_is_jr,
    input  logic [1:0]       EXE_branch_type,
    input  logic             EXE_branch_hit,
    input  logic [31:0]      EXE_branch_next_pc,
    input  logic             EXE_predict_pc_dir,
    input  logic [31:0]      EXE_predict_pc,
    input  logic             EXE_hit,
    input  logic [31:0]      EXE_pc,
    input  logic [31:0]      EXE_btb_branch_pc,
    input  logic             ID_valid,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_front,
    output logic             flush_ds,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [31:0]      upd_pc,
    output logic [31:0]      upd_target,
    output logic             upd_taken,
    output logic [1:0]       upd_type,
    output logic             upd_alloc,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispredict,
    output logic [CNT_W-1:0] cnt_upd_drop
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             likely_nt_q, likely_nt_d;
    logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
    logic [CNT_W-1:0] cnt_mispredict_q, cnt_mispredict_d;
    logic [CNT_W-1:0] cnt_upd_drop_q, cnt_upd_drop_d;

    logic             resolve;
    logic             mispredict;
    logic             tgt_check;
    logic [31:0]      correct_pc;
    logic             alloc;
    logic             upd_drop;
    logic             in_redirect;
    upd_rec_t         push_rec;
    upd_rec_t         head_rec;

    always_comb begin
        resolve    = exe_valid & EXE_is_branch & EXE_wr;
        correct_pc = EXE_branch_hit ? EXE_branch_next_pc : pc_plus8(EXE_pc);
        // A taken jr never has a trusted target, so its target is always compared.
        tgt_check  = EXE_branch_hit & (EXE_predict_pc_dir | EXE_is_jr);
        mispredict = (EXE_predict_pc_dir != EXE_branch_hit)
                   | (tgt_check & (EXE_predict_pc != EXE_branch_next_pc));
        alloc      = ~EXE_hit | (EXE_btb_branch_pc != EXE_pc);

        push_rec.pc     = EXE_pc;
        push_rec.target = correct_pc;
        push_rec.taken  = EXE_branch_hit;
        push_rec.btype  = EXE_branch_type;
        push_rec.alloc  = alloc;
    end

    // Next-state logic; flush overrides every state.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        likely_nt_d   = likely_nt_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (resolve & mispredict) begin
                        state_d       = ID_valid ? ST_REDIRECT : ST_WAIT_DS;
                        redirect_pc_d = correct_pc;
                        likely_nt_d   = EXE_is_branch_likely & ~EXE_branch_hit;
                    end
                end
                ST_WAIT_DS: begin
                    if (ID_valid) begin
                        state_d = ST_REDIRECT;
                    end
                end
                ST_REDIRECT: state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_redirect    = (state_q == ST_REDIRECT) & ~flush;
        redirect_valid = in_redirect;
        flush_front    = in_redirect;
        flush_ds       = in_redirect & likely_nt_q;
        redirect_pc    = redirect_pc_q;
    end

    always_comb begin
        cnt_branch_d     = cnt_branch_q + {{(CNT_W-1){1'b0}}, resolve};
        cnt_mispredict_d = cnt_mispredict_q + {{(CNT_W-1){1'b0}}, resolve & mispredict};
        cnt_upd_drop_d   = cnt_upd_drop_q + {{(CNT_W-1){1'b0}}, upd_drop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            redirect_pc_q    <= '0;
            likely_nt_q      <= 1'b0;
            cnt_branch_q     <= '0;
            cnt_mispredict_q <= '0;
            cnt_upd_drop_q   <= '0;
        end else begin
            state_q          <= state_d;
            redirect_pc_q    <= redirect_pc_d;
            likely_nt_q      <= likely_nt_d;
            cnt_branch_q     <= cnt_branch_d;
            cnt_mispredict_q <= cnt_mispredict_d;
            cnt_upd_drop_q   <= cnt_upd_drop_d;
        end
    end

    bp_upd_fifo #(
        .DEPTH (UPD_DEPTH),
        .W     (UPD_REC_W)
    ) u_upd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (resolve),
        .push_data (push_rec),
        .out_valid (upd_valid),
        .out_ready (upd_ready),
        .out_data  (head_rec),
        .drop      (upd_drop)
    );

    always_comb begin
        upd_pc         = head_rec.pc;
        upd_target     = head_rec.target;
        upd_taken      = head_rec.taken;
        upd_type       = head_rec.btype;
        upd_alloc      = head_rec.alloc;
        cnt_branch     = cnt_branch_q;
        cnt_mispredict = cnt_mispredict_q;
        cnt_upd_drop   = cnt_upd_drop_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_exe_branch_resolve.sv
// ============================================================================
// Module   : tb_exe_branch_resolve
// Purpose  : Scoreboard bench for exe_branch_resolve (redirects, delay slot,
//            flush abort, update FIFO backpressure/drop, counters).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_exe_branch_resolve;
    import exe_branch_resolve_pkg::*;

    localparam int UPD_DEPTH = 2;
    localparam int CNT_W     = 32;

    logic             clk = 1'b0;
    logic             reset, flush, EXE_wr, exe_valid, EXE_is_branch;
    logic             EXE_is_branch_likely, EXE_is_jr, EXE_branch_hit;
    logic [1:0]       EXE_branch_type;
    logic [31:0]      EXE_branch_next_pc, EXE_predict_pc, EXE_pc, EXE_btb_branch_pc;
    logic             EXE_predict_pc_dir, EXE_hit, ID_valid, upd_ready;
    logic             redirect_valid, flush_front, flush_ds, upd_valid;
    logic [31:0]      redirect_pc, upd_pc, upd_target;
    logic             upd_taken, upd_alloc;
    logic [1:0]       upd_type;
    logic [CNT_W-1:0] cnt_branch, cnt_mispredict, cnt_upd_drop;

    always #5 clk = ~clk;

    exe_branch_resolve #(.UPD_DEPTH(UPD_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .EXE_wr(EXE_wr),
        .exe_valid(exe_valid), .EXE_is_branch(EXE_is_branch),
        .EXE_is_branch_likely(EXE_is_branch_likely), .EXE_is_jr(EXE_is_jr),
        .EXE_branch_type(EXE_branch_type), .EXE_branch_hit(EXE_branch_hit),
        .EXE_branch_next_pc(EXE_branch_next_pc), .EXE_predict_pc_dir(EXE_predict_pc_dir),
        .EXE_predict_pc(EXE_predict_pc), .EXE_hit(EXE_hit), .EXE_pc(EXE_pc),
        .EXE_btb_branch_pc(EXE_btb_branch_pc), .ID_valid(ID_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_front(flush_front), .flush_ds(flush_ds), .upd_valid(upd_valid),
        .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_type(upd_type), .upd_alloc(upd_alloc),
        .cnt_branch(cnt_branch), .cnt_mispredict(cnt_mispredict),
        .cnt_upd_drop(cnt_upd_drop)
    );

    int       n_checks = 0;
    int       n_pass   = 0;
    int       exp_branch = 0, exp_mis = 0, exp_drop = 0, exp_rv = 0, rv_seen = 0;
    upd_rec_t upd_q[$];
    upd_rec_t mon_rec;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Update-port scoreboard: compare every handshaken record in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (redirect_valid) rv_seen++;
            if (upd_valid && upd_ready) begin
                if (upd_q.size() == 0) begin
                    check("upd_unexpected", 1, 0);
                end else begin
                    mon_rec = upd_q.pop_front();
                    check("upd_rec", {upd_pc, upd_target, upd_taken, upd_type, upd_alloc}, mon_rec);
                end
            end
        end
    end

    task automatic branch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input logic pdir, input logic [31:0] ppc, input logic likely,
                          input logic jr, input logic btb_hit, input logic [31:0] btb_pc,
                          input logic [1:0] btype, input logic drop);
        logic     mis;
        upd_rec_t r;
        mis = (pdir != taken) || (taken && (pdir || jr) && (ppc != tgt));
        r.pc     = pc;
        r.target = taken ? tgt : pc + 32'd8;
        r.taken  = taken;
        r.btype  = btype;
        r.alloc  = !btb_hit || (btb_pc != pc);
        if (!drop) upd_q.push_back(r);
        exp_branch++;
        if (mis) exp_mis++;
        if (drop) exp_drop++;
        EXE_pc = pc; EXE_branch_hit = taken; EXE_branch_next_pc = tgt;
        EXE_predict_pc_dir = pdir; EXE_predict_pc = ppc; EXE_is_branch_likely = likely;
        EXE_is_jr = jr; EXE_hit = btb_hit; EXE_btb_branch_pc = btb_pc; EXE_branch_type = btype;
        exe_valid = 1'b1; EXE_is_branch = 1'b1; EXE_wr = 1'b1;
        tick();
        exe_valid = 1'b0; EXE_is_branch = 1'b0; EXE_wr = 1'b0;
        EXE_is_branch_likely = 1'b0; EXE_is_jr = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (upd_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check(tag, upd_q.size(), 0);
    endtask

    task automatic check_redirect(input string tag, input logic [31:0] pc, input logic ds);
        @(negedge clk);
        check({tag, "_valid"}, redirect_valid, 1);
        check({tag, "_pc"}, redirect_pc, pc);
        check({tag, "_front"}, flush_front, 1);
        check({tag, "_ds"}, flush_ds, ds);
        tick();
        @(negedge clk);
        check({tag, "_one_cycle"}, redirect_valid, 0);
        exp_rv++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; EXE_wr = 1'b0; exe_valid = 1'b0; EXE_is_branch = 1'b0;
        EXE_is_branch_likely = 1'b0; EXE_is_jr = 1'b0; EXE_branch_type = BR_TYPE_COND;
        EXE_branch_hit = 1'b0; EXE_branch_next_pc = '0; EXE_predict_pc_dir = 1'b0;
        EXE_predict_pc = '0; EXE_hit = 1'b0; EXE_pc = '0; EXE_btb_branch_pc = '0;
        ID_valid = 1'b1; upd_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_redirect", {redirect_valid, flush_front, flush_ds}, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_counters", {cnt_branch, cnt_mispredict, cnt_upd_drop}, 0);
        tick();
        reset = 1'b0;
        tick();

        // Correctly predicted not-taken branch
        branch(32'h8000_0100, 0, 32'h8000_0180, 0, 32'h0, 0, 0, 1, 32'h8000_0100, BR_TYPE_COND, 0);
        @(negedge clk);
        check("nt_no_redirect", redirect_valid, 0);
        check("nt_target", upd_target, 32'h8000_0108);
        check("nt_cnt_branch", cnt_branch, 1);
        check("nt_cnt_mis", cnt_mispredict, 0);
        wait_drain("nt_drain");

        // Taken, predicted not-taken, delay slot present
        branch(32'h8000_0104, 1, 32'h8000_0200, 0, 32'h0, 0, 0, 1, 32'h8000_0104, BR_TYPE_COND, 0);
        check_redirect("mis_ds", 32'h8000_0200, 0);
        check("mis_cnt", cnt_mispredict, 1);
        wait_drain("mis_drain");

        // Same mispredict, delay slot absent for three cycles
        ID_valid = 1'b0;
        branch(32'h8000_0104, 1, 32'h8000_0200, 0, 32'h0, 0, 0, 1, 32'h8000_0104, BR_TYPE_COND, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_ds_hold", redirect_valid, 0);
            tick();
        end
        ID_valid = 1'b1;
        @(negedge clk);
        check("wait_ds_arrive", redirect_valid, 0);
        tick();
        check_redirect("wait_ds", 32'h8000_0200, 0);
        wait_drain("wait_ds_drain");

        // Likely branch not taken but predicted taken: nullify delay slot
        branch(32'h8000_0300, 0, 32'h8000_0400, 1, 32'h8000_0400, 1, 0, 1, 32'h8000_0300, BR_TYPE_COND, 0);
        check_redirect("likely_nt", 32'h8000_0308, 1);
        wait_drain("likely_drain");

        // Taken jr with stale target and BTB miss
        branch(32'h8000_0500, 1, 32'h8000_1000, 1, 32'h8000_2000, 0, 1, 0, 32'h0, BR_TYPE_RET, 0);
        check_redirect("jr", 32'h8000_1000, 0);
        wait_drain("jr_drain");

        // Flush lands on the redirect cycle
        branch(32'h8000_0600, 1, 32'h8000_0700, 0, 32'h0, 0, 0, 1, 32'h8000_0600, BR_TYPE_JUMP, 0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_abort", {redirect_valid, flush_front, flush_ds}, 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle", redirect_valid, 0);
        wait_drain("flush_drain");

        // Backpressure: three branches into a two-entry queue
        upd_ready = 1'b0;
        branch(32'h8000_0800, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h8000_0800, BR_TYPE_COND, 0);
        branch(32'h8000_0900, 1, 32'h8000_0a00, 1, 32'h8000_0a00, 0, 0, 0, 32'h0, BR_TYPE_CALL, 0);
        branch(32'h8000_0b00, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h8000_0b00, BR_TYPE_COND, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", upd_valid, 1);
            check("stall_payload", {upd_pc, upd_target, upd_taken, upd_type, upd_alloc}, upd_q[0]);
            tick();
        end
        check("stall_drop", cnt_upd_drop, 1);
        upd_ready = 1'b1;
        wait_drain("stall_drain");

        // Fall-through address wraps
        branch(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'hFFFF_FFFC, BR_TYPE_COND, 0);
        @(negedge clk);
        check("wrap_target", upd_target, 32'h0000_0004);
        wait_drain("wrap_drain");

        tick();
        check("cnt_branch", cnt_branch, exp_branch);
        check("cnt_mispredict", cnt_mispredict, exp_mis);
        check("cnt_upd_drop", cnt_upd_drop, exp_drop);
        check("redirect_count", rv_seen, exp_rv);

        // Asynchronous reset mid-cycle with an entry pending
        upd_ready = 1'b0;
        branch(32'h8000_0c00, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h8000_0c00, BR_TYPE_COND, 0);
        #1;
        reset = 1'b1;
        #1;
        check("async_cnt", {cnt_branch, cnt_mispredict, cnt_upd_drop}, 0);
        check("async_fifo", upd_valid, 0);
        upd_q.delete();
        tick();
        reset = 1'b0;
        upd_ready = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
